// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine.
// Runs one data-bus transaction per EX/MEM load or store, steering store
// bytes onto the bus lanes and aligning/extending load data. It holds the
// pipeline through stall_mem until the bus answers or the access times out.
module mem_access_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_en,
  input  logic             Mem_rw,
  input  logic [2:0]       size_type,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             stall_mem,
  output logic [WIDTH-1:0] load_data,
  output logic             ld_valid,
  output logic             misalign_err,
  output logic             bus_err,
  output logic             dbus_req,
  output logic             dbus_we,
  output logic [WIDTH-1:0] dbus_addr,
  output logic [3:0]       dbus_be,
  output logic [WIDTH-1:0] dbus_wdata,
  input  logic             dbus_ack,
  input  logic [WIDTH-1:0] dbus_rdata
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Last counter value before the access is abandoned (unused when TIMEOUT==0).
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  // funct3 encodings
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       size_q;
  logic [1:0]       off_q;
  logic             misalign;
  logic             access_start;
  logic             in_req;
  logic             timeout_hit;
  logic             req_ack;
  logic             req_abandon;

  // Halfwords must sit on even addresses, words on multiples of four;
  // the three unused funct3 codes are always rejected.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B, SZ_BU: bad = 1'b0;
      SZ_H, SZ_HU: bad = off[0];
      SZ_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte enables for a store; loads always fetch the whole word.
  function automatic logic [3:0] store_be(input logic we, input logic [2:0] size,
                                          input logic [1:0] off);
    logic [3:0] be;
    if (!we) begin
      be = 4'b1111;
    end else begin
      case (size[1:0])
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Store data replicated across every lane it could land in, so the
  // byte enables alone select the target bytes.
  function automatic logic [WIDTH-1:0] store_lanes(input logic we, input logic [2:0] size,
                                                   input logic [WIDTH-1:0] sd);
    logic [WIDTH-1:0] wd;
    if (!we) begin
      wd = '0;
    end else begin
      case (size[1:0])
        2'b00:   wd = {4{sd[7:0]}};
        2'b01:   wd = {2{sd[15:0]}};
        default: wd = sd;
      endcase
    end
    return wd;
  endfunction

  // Shift the addressed bytes down to bit 0, then sign- or zero-extend.
  function automatic logic [WIDTH-1:0] format_load(input logic [2:0] size, input logic [1:0] off,
                                                   input logic [WIDTH-1:0] rdata);
    logic [WIDTH-1:0]  sh;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic [WIDTH-1:0]  res;
    sh  = rdata >> {off, 3'b000};
    b8  = sh[7:0];
    h16 = sh[15:0];
    case (size)
      SZ_B:    res = WIDTH'(b8);
      SZ_H:    res = WIDTH'(h16);
      SZ_BU:   res = {{(WIDTH-8){1'b0}}, sh[7:0]};
      SZ_HU:   res = {{(WIDTH-16){1'b0}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  assign misalign     = is_misaligned(size_type, addr[1:0]);
  assign access_start = (state == IDLE) && mem_en && !misalign;
  assign in_req       = (state == REQ);
  assign timeout_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign req_ack      = in_req && dbus_ack;
  assign req_abandon  = in_req && !dbus_ack && timeout_hit;

  // Combinational handshake back to the pipeline; forced low while in reset.
  assign stall_mem    = !reset && (access_start || in_req);
  assign misalign_err = !reset && (state == IDLE) && mem_en && misalign;
  assign dbus_req     = in_req;

  // Next-state selection for the IDLE -> REQ -> DONE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (access_start) state_nxt = REQ;
      REQ:     if (dbus_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, timeout counter and the one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ld_valid <= req_ack && !dbus_we;
      bus_err  <= req_abandon;
      if (access_start) begin
        cnt <= '0;
      end else if (in_req && !dbus_ack) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Capture the access at issue; bus outputs stay frozen until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= 4'b0000;
      dbus_wdata <= '0;
      size_q     <= 3'b000;
      off_q      <= 2'b00;
    end else if (access_start) begin
      dbus_we    <= Mem_rw;
      dbus_addr  <= {addr[WIDTH-1:2], 2'b00};
      dbus_be    <= store_be(Mem_rw, size_type, addr[1:0]);
      dbus_wdata <= store_lanes(Mem_rw, size_type, store_data);
      size_q     <= size_type;
      off_q      <= addr[1:0];
    end
  end

  // Load result: updated on a completed load, cleared on a timeout, else held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_data <= '0;
    end else if (req_ack && !dbus_we) begin
      load_data <= format_load(size_q, off_q, dbus_rdata);
    end else if (req_abandon) begin
      load_data <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for the MEM-stage load/store engine.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic        Mem_rw;
  logic [2:0]  size_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall_mem;
  logic [31:0] load_data;
  logic        ld_valid;
  logic        misalign_err;
  logic        bus_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WIDTH(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .Mem_rw(Mem_rw),
    .size_type(size_type), .addr(addr), .store_data(store_data),
    .stall_mem(stall_mem), .load_data(load_data), .ld_valid(ld_valid),
    .misalign_err(misalign_err), .bus_err(bus_err), .dbus_req(dbus_req),
    .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_en = 1'b0; Mem_rw = 1'b0; size_type = 3'b000;
    addr = 32'h0; store_data = 32'h0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    tick; tick;
    checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dbus_req); end
    checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_mem); end
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL reset_ldv: got %b expected 0", ld_valid); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_buserr: got %b expected 0", bus_err); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_ldata: got %h expected 0", load_data); end
    checks++; if (dbus_be !== 4'h0) begin errors++; $display("FAIL reset_be: got %b expected 0000", dbus_be); end
    reset = 1'b0;
    tick;
  endtask

  // Load with zero-wait ack; ends just after leaving DONE, mem_en still set.
  task automatic run_load(input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    mem_en = 1'b1; Mem_rw = 1'b0; size_type = sz; addr = a; store_data = 32'h0;
    #1;
    checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL ld_stall_issue a=%h: got %b expected 1", a, stall_mem); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL ld_misalign a=%h: got %b expected 0", a, misalign_err); end
    tick;
    checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL ld_req a=%h: got %b expected 1", a, dbus_req); end
    checks++; if (dbus_we !== 1'b0) begin errors++; $display("FAIL ld_we a=%h: got %b expected 0", a, dbus_we); end
    checks++; if (dbus_addr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL ld_addr: got %h expected %h", dbus_addr, a & 32'hFFFF_FFFC); end
    checks++; if (dbus_be !== 4'b1111) begin errors++; $display("FAIL ld_be a=%h: got %b expected 1111", a, dbus_be); end
    checks++; if (dbus_wdata !== 32'h0) begin errors++; $display("FAIL ld_wdata a=%h: got %h expected 0", a, dbus_wdata); end
    checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL ld_stall_req a=%h: got %b expected 1", a, stall_mem); end
    dbus_ack = 1'b1; dbus_rdata = rd;
    tick;
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL ld_stall_done a=%h: got %b expected 0", a, stall_mem); end
    checks++; if (ld_valid !== 1'b1) begin errors++; $display("FAIL ld_valid a=%h: got %b expected 1", a, ld_valid); end
    checks++; if (load_data !== exp) begin errors++; $display("FAIL ld_data a=%h: got %h expected %h", a, load_data, exp); end
    checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL ld_req_done a=%h: got %b expected 0", a, dbus_req); end
    tick;
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL ld_valid_pulse a=%h: got %b expected 0", a, ld_valid); end
  endtask

  // Store acked in REQ cycle waits+1; checks total stall length.
  task automatic run_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] sd,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd, input int waits);
    int stalls;
    stalls = 0;
    mem_en = 1'b1; Mem_rw = 1'b1; size_type = sz; addr = a; store_data = sd;
    #1;
    if (stall_mem === 1'b1) stalls++;
    tick;
    for (int i = 0; i <= waits; i++) begin
      if (stall_mem === 1'b1) stalls++;
      checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL st_req a=%h cyc%0d: got %b expected 1", a, i, dbus_req); end
      checks++; if (dbus_we !== 1'b1) begin errors++; $display("FAIL st_we a=%h cyc%0d: got %b expected 1", a, i, dbus_we); end
      checks++; if (dbus_be !== exp_be) begin errors++; $display("FAIL st_be a=%h cyc%0d: got %b expected %b", a, i, dbus_be, exp_be); end
      checks++; if (dbus_wdata !== exp_wd) begin errors++; $display("FAIL st_wdata a=%h cyc%0d: got %h expected %h", a, i, dbus_wdata, exp_wd); end
      checks++; if (dbus_addr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL st_addr cyc%0d: got %h expected %h", i, dbus_addr, a & 32'hFFFF_FFFC); end
      if (i == waits) dbus_ack = 1'b1;
      tick;
    end
    dbus_ack = 1'b0;
    checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL st_stall_done a=%h: got %b expected 0", a, stall_mem); end
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL st_ldvalid a=%h: got %b expected 0", a, ld_valid); end
    checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL st_req_done a=%h: got %b expected 0", a, dbus_req); end
    checks++; if (stalls !== waits + 2) begin errors++; $display("FAIL st_stall_len a=%h: got %0d expected %0d", a, stalls, waits + 2); end
    tick;
  endtask

  task automatic run_misalign(input logic [2:0] sz, input logic [31:0] a);
    mem_en = 1'b1; Mem_rw = 1'b0; size_type = sz; addr = a; store_data = 32'h0;
    #1;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_flag sz=%b a=%h: got %b expected 1", sz, a, misalign_err); end
    checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL mis_stall sz=%b a=%h: got %b expected 0", sz, a, stall_mem); end
    tick;
    checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL mis_req sz=%b a=%h: got %b expected 0", sz, a, dbus_req); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_flag2 sz=%b a=%h: got %b expected 1", sz, a, misalign_err); end
    mem_en = 1'b0;
    #1;
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear sz=%b a=%h: got %b expected 0", sz, a, misalign_err); end
    tick;
  endtask

  task automatic test_lw;
    run_load(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
  endtask

  task automatic test_load_ext;
    run_load(3'b000, 32'h0000_0203, 32'h8011_2233, 32'hFFFF_FF80);
    run_load(3'b100, 32'h0000_0203, 32'h8011_2233, 32'h0000_0080);
    run_load(3'b000, 32'h0000_0201, 32'h8011_2233, 32'h0000_0022);
    run_load(3'b001, 32'h0000_0202, 32'h8001_5555, 32'hFFFF_8001);
    run_load(3'b101, 32'h0000_0202, 32'h8001_5555, 32'h0000_8001);
  endtask

  task automatic test_stores;
    run_store(3'b000, 32'h0000_0041, 32'h1234_5678, 4'b0010, 32'h7878_7878, 2);
    run_store(3'b001, 32'h0000_0042, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_CCDD, 0);
    run_store(3'b010, 32'h0000_0044, 32'h1122_3344, 4'b1111, 32'h1122_3344, 0);
  endtask

  // Store immediately followed by a load: the load is issued in the cycle after DONE.
  task automatic test_back_to_back;
    run_store(3'b001, 32'h0000_0060, 32'h0000_BEEF, 4'b0011, 32'hBEEF_BEEF, 0);
    run_load(3'b010, 32'h0000_0060, 32'hCAFE_F00D, 32'hCAFE_F00D);
    mem_en = 1'b0;
    tick;
  endtask

  task automatic test_misalign;
    run_misalign(3'b010, 32'h0000_0102);
    run_misalign(3'b011, 32'h0000_0100);
    run_misalign(3'b001, 32'h0000_0201);
    run_misalign(3'b111, 32'h0000_0000);
  endtask

  task automatic test_timeout;
    mem_en = 1'b1; Mem_rw = 1'b0; size_type = 3'b010; addr = 32'h0000_0300;
    #1;
    checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL to_stall_issue: got %b expected 1", stall_mem); end
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL to_req cyc%0d: got %b expected 1", i, dbus_req); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_early cyc%0d: got %b expected 0", i, bus_err); end
      tick;
    end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_buserr: got %b expected 1", bus_err); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL to_ldata: got %h expected 0", load_data); end
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL to_ldvalid: got %b expected 0", ld_valid); end
    checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL to_req_done: got %b expected 0", dbus_req); end
    checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL to_stall_done: got %b expected 0", stall_mem); end
    mem_en = 1'b0; dbus_ack = 1'b1; dbus_rdata = 32'h5555_AAAA;
    tick;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b expected 0", bus_err); end
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL to_stray_ldv: got %b expected 0", ld_valid); end
    tick;
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL to_stray_ldv2: got %b expected 0", ld_valid); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL to_stray_ldata: got %h expected 0", load_data); end
    checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL to_stray_req: got %b expected 0", dbus_req); end
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    tick;
  endtask

  task automatic test_reset_mid_req;
    mem_en = 1'b1; Mem_rw = 1'b0; size_type = 3'b010; addr = 32'h0000_0400;
    tick;
    tick;
    checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_pre: got %b expected 1", dbus_req); end
    reset = 1'b1;
    #1;
    checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b expected 0", dbus_req); end
    checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0", stall_mem); end
    tick;
    reset = 1'b0; mem_en = 1'b0;
    tick;
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ldv: got %b expected 0", ld_valid); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_mid_buserr: got %b expected 0", bus_err); end
    checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req_after: got %b expected 0", dbus_req); end
    run_load(3'b010, 32'h0000_0500, 32'h0BAD_F00D, 32'h0BAD_F00D);
    mem_en = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_lw;
    test_load_ext;
    test_stores;
    test_back_to_back;
    test_misalign;
    test_timeout;
    test_reset_mid_req;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
